// File: rtl/m_dm_access.sv
// m_dm_access: M-stage data memory access sequencer.
// Issues one handshaked memory access per M-stage load/store. The pipeline
// is held while the access is outstanding. The raw read word, extension
// opcode and byte address are registered for the downstream load extender.
// Misaligned accesses are flagged without touching memory. Accesses that
// never see mem_ack are aborted as bus errors after MAX_WAIT BUSY cycles.
module m_dm_access #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_we,
  input  logic [1:0]  m_size,
  input  logic [2:0]  m_ext_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        m_stall,
  output logic        rdata_valid,
  output logic [31:0] m_pre_rdata,
  output logic [2:0]  ext_op_out,
  output logic [31:0] addr_out,
  output logic        m_adel,
  output logic        m_ades,
  output logic        m_buserr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  wait_cnt;
  logic        we_q;
  logic [2:0]  ext_op_q;
  logic [31:0] addr_q;
  logic        misaligned;
  logic        accept;
  logic        timeout;
  logic        stall_c;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Alignment check: the reserved size code behaves like a word access.
  always_comb begin
    misaligned = 1'b0;
    unique case (m_size)
      2'b01:   misaligned = m_addr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = |m_addr[1:0];
    endcase
  end

  // Byte enables and lane-replicated store data. Loads always read the whole word.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = m_wdata;
    unique case (m_size)
      2'b01: begin
        wdata_calc = {2{m_wdata[15:0]}};
        if (m_we) be_calc = m_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        wdata_calc = {4{m_wdata[7:0]}};
        if (m_we) be_calc = 4'b0001 << m_addr[1:0];
      end
      default: begin
        wdata_calc = m_wdata;
        be_calc    = 4'b1111;
      end
    endcase
  end

  assign accept  = (state == IDLE) && m_valid && !misaligned;
  assign timeout = (state == BUSY) && !mem_ack && (wait_cnt == LAST_WAIT);
  assign m_adel  = (state == IDLE) && m_valid && misaligned && !m_we;
  assign m_ades  = (state == IDLE) && m_valid && misaligned && m_we;
  // A reset during BUSY releases the pipeline immediately, even if M still holds an access.
  assign m_stall = stall_c && reset;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and stall generation. An ack beats a timeout in the same cycle.
  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = BUSY;
          stall_c  = 1'b1;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (mem_ack || timeout) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory interface, holding copies, wait counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      rdata_valid <= 1'b0;
      m_pre_rdata <= '0;
      ext_op_out  <= '0;
      addr_out    <= '0;
      m_buserr    <= 1'b0;
      wait_cnt    <= '0;
      we_q        <= 1'b0;
      ext_op_q    <= '0;
      addr_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          rdata_valid <= 1'b0;
          m_buserr    <= 1'b0;
          if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= m_we;
            mem_addr  <= {m_addr[31:2], 2'b00};
            mem_be    <= be_calc;
            mem_wdata <= wdata_calc;
            we_q      <= m_we;
            ext_op_q  <= m_ext_op;
            addr_q    <= m_addr;
            wait_cnt  <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            if (!we_q) m_pre_rdata <= mem_rdata;
            ext_op_out  <= ext_op_q;
            addr_out    <= addr_q;
            rdata_valid <= 1'b1;
          end else if (timeout) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            m_pre_rdata <= '0;
            ext_op_out  <= ext_op_q;
            addr_out    <= addr_q;
            rdata_valid <= 1'b1;
            m_buserr    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          rdata_valid <= 1'b0;
          m_buserr    <= 1'b0;
          wait_cnt    <= '0;
        end
        default: begin
          rdata_valid <= 1'b0;
          m_buserr    <= 1'b0;
        end
      endcase
    end
  end

endmodule
